// File: rtl/crossbar_fifo_pkt.sv
// Single-clock stream FIFO with an optional store-and-forward packet mode.
// Occupancy and packet counts are registered; all flags derive from them.
module crossbar_fifo_pkt #(
    parameter int FIFO_DEPTH    = 16,
    parameter int FIFO_WIDTH    = 32,
    parameter int PACKET_MODE   = 0,
    parameter int AFULL_THRESH  = FIFO_DEPTH - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          s_axis_data_tvalid,
    output logic                          s_axis_data_tready,
    input  logic [FIFO_WIDTH-1:0]         s_axis_data_tdata,
    input  logic                          s_axis_data_tlast,
    output logic                          m_axis_data_tvalid,
    input  logic                          m_axis_data_tready,
    output logic [FIFO_WIDTH-1:0]         m_axis_data_tdata,
    output logic                          m_axis_data_tlast,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level,
    output logic [$clog2(FIFO_DEPTH):0]   pkt_count,
    output logic                          almost_full,
    output logic                          almost_empty
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [FIFO_WIDTH:0] mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [CW-1:0]       fill_q, pkt_q;
    logic                rdy_q;
    logic                full, wr_en, rd_en, wr_last, rd_last;

    assign full               = (fill_q == CW'(FIFO_DEPTH));
    // rdy_q holds ready low through reset without touching the read side
    assign s_axis_data_tready = rdy_q && !full;

    always_comb begin
        m_axis_data_tvalid = (fill_q != '0);
        // Full with no complete packet: release anyway so oversize packets drain
        if (PACKET_MODE != 0)
            m_axis_data_tvalid = m_axis_data_tvalid && ((pkt_q != '0) || full);
    end

    assign {m_axis_data_tlast, m_axis_data_tdata} = mem[rd_ptr];

    assign wr_en   = s_axis_data_tvalid && s_axis_data_tready;
    assign rd_en   = m_axis_data_tvalid && m_axis_data_tready;
    assign wr_last = wr_en && s_axis_data_tlast;
    assign rd_last = rd_en && m_axis_data_tlast;

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= {s_axis_data_tlast, s_axis_data_tdata};
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rdy_q  <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill_q <= '0;
            pkt_q  <= '0;
        end else begin
            rdy_q <= 1'b1;
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   fill_q <= fill_q + CW'(1);
                2'b01:   fill_q <= fill_q - CW'(1);
                default: fill_q <= fill_q;
            endcase
            case ({wr_last, rd_last})
                2'b10:   pkt_q <= pkt_q + CW'(1);
                2'b01:   pkt_q <= pkt_q - CW'(1);
                default: pkt_q <= pkt_q;
            endcase
        end
    end

    assign fill_level   = fill_q;
    assign pkt_count    = pkt_q;
    assign almost_full  = (fill_q >= CW'(AFULL_THRESH));
    assign almost_empty = (fill_q <= CW'(AEMPTY_THRESH));
endmodule

// File: tb/tb_crossbar_fifo_pkt.sv
// Directed bench: a word-mode and a packet-mode FIFO (depth 4, width 8)
// driven from vector tables and short hand-written sequences.
module tb_crossbar_fifo_pkt;
    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    logic       w_sv, w_sr, w_sl, w_mv, w_mr, w_ml, w_af, w_ae;
    logic [7:0] w_sd, w_md;
    logic [2:0] w_fill, w_pkt;
    logic       p_sv, p_sr, p_sl, p_mv, p_mr, p_ml, p_af, p_ae;
    logic [7:0] p_sd, p_md;
    logic [2:0] p_fill, p_pkt;

    crossbar_fifo_pkt #(.FIFO_DEPTH(4), .FIFO_WIDTH(8), .PACKET_MODE(0)) u_word (
        .clk(clk), .resetn(resetn),
        .s_axis_data_tvalid(w_sv), .s_axis_data_tready(w_sr),
        .s_axis_data_tdata(w_sd), .s_axis_data_tlast(w_sl),
        .m_axis_data_tvalid(w_mv), .m_axis_data_tready(w_mr),
        .m_axis_data_tdata(w_md), .m_axis_data_tlast(w_ml),
        .fill_level(w_fill), .pkt_count(w_pkt),
        .almost_full(w_af), .almost_empty(w_ae)
    );

    crossbar_fifo_pkt #(.FIFO_DEPTH(4), .FIFO_WIDTH(8), .PACKET_MODE(1)) u_pkt (
        .clk(clk), .resetn(resetn),
        .s_axis_data_tvalid(p_sv), .s_axis_data_tready(p_sr),
        .s_axis_data_tdata(p_sd), .s_axis_data_tlast(p_sl),
        .m_axis_data_tvalid(p_mv), .m_axis_data_tready(p_mr),
        .m_axis_data_tdata(p_md), .m_axis_data_tlast(p_ml),
        .fill_level(p_fill), .pkt_count(p_pkt),
        .almost_full(p_af), .almost_empty(p_ae)
    );

    typedef struct {
        logic sv; logic [7:0] sd; logic sl; logic mr;
        logic e_sr; logic e_mv; logic [7:0] e_md; logic e_ml;
        logic [2:0] e_fill; logic [2:0] e_pkt; logic e_af; logic e_ae;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t tbl[10];
        int   widx, ridx;
        bit   esc_seen;

        // sv  sd     sl mr | sr mv md     ml fill pkt af ae
        tbl[0] = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 3'd0, 1'b0, 1'b1};
        tbl[1] = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 3'd1, 3'd0, 1'b0, 1'b1};
        tbl[2] = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 3'd2, 3'd0, 1'b1, 1'b1};
        tbl[3] = '{1'b1, 8'h44, 1'b1, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 3'd3, 3'd0, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 3'd4, 3'd1, 1'b1, 1'b0};
        tbl[5] = '{1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 3'd4, 3'd1, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h22, 1'b0, 3'd3, 3'd1, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h33, 1'b0, 3'd2, 3'd1, 1'b1, 1'b1};
        tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h44, 1'b1, 3'd1, 3'd1, 1'b0, 1'b1};
        tbl[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 3'd0, 1'b0, 1'b1};

        resetn = 1'b0;
        w_sv = 0; w_sd = 0; w_sl = 0; w_mr = 0;
        p_sv = 0; p_sd = 0; p_sl = 0; p_mr = 0;
        tick(); tick();
        chk("rst_s_tready", 32'(w_sr), 0);
        chk("rst_m_tvalid", 32'(w_mv), 0);
        chk("rst_fill", 32'(w_fill), 0);
        chk("rst_pkt", 32'(w_pkt), 0);
        chk("rst_afull", 32'(w_af), 0);
        chk("rst_aempty", 32'(w_ae), 1);
        chk("rst_p_m_tvalid", 32'(p_mv), 0);
        resetn = 1'b1;
        tick();
        chk("post_rst_s_tready", 32'(w_sr), 1);

        // Fill to full with refused writes, then drain in order
        for (int i = 0; i < 10; i++) begin
            w_sv = tbl[i].sv; w_sd = tbl[i].sd; w_sl = tbl[i].sl; w_mr = tbl[i].mr;
            #1;
            chk($sformatf("tbl%0d_s_tready", i), 32'(w_sr), 32'(tbl[i].e_sr));
            chk($sformatf("tbl%0d_m_tvalid", i), 32'(w_mv), 32'(tbl[i].e_mv));
            chk($sformatf("tbl%0d_fill", i), 32'(w_fill), 32'(tbl[i].e_fill));
            chk($sformatf("tbl%0d_pkt", i), 32'(w_pkt), 32'(tbl[i].e_pkt));
            chk($sformatf("tbl%0d_afull", i), 32'(w_af), 32'(tbl[i].e_af));
            chk($sformatf("tbl%0d_aempty", i), 32'(w_ae), 32'(tbl[i].e_ae));
            if (tbl[i].e_mv) begin
                chk($sformatf("tbl%0d_m_tdata", i), 32'(w_md), 32'(tbl[i].e_md));
                chk($sformatf("tbl%0d_m_tlast", i), 32'(w_ml), 32'(tbl[i].e_ml));
            end
            tick();
        end

        // Streaming 20 words through an initially empty FIFO, across pointer wrap
        for (int i = 0; i <= 20; i++) begin
            w_sv = (i < 20); w_sd = 8'(i + 1); w_sl = 0; w_mr = 1;
            #1;
            chk("stream_s_tready", 32'(w_sr), 1);
            if (i == 0) begin
                chk("stream_first_m_tvalid", 32'(w_mv), 0);
            end else begin
                chk("stream_m_tvalid", 32'(w_mv), 1);
                chk("stream_m_tdata", 32'(w_md), 32'(i));
                chk("stream_fill", 32'(w_fill), 1);
            end
            tick();
        end
        w_sv = 0; w_mr = 0;
        #1;
        chk("stream_end_fill", 32'(w_fill), 0);

        // Packet mode: held until tlast written
        p_sv = 1; p_sd = 8'hA0; p_sl = 0; p_mr = 1;
        #1; chk("pkt_a0_m_tvalid", 32'(p_mv), 0);
        tick(); p_sd = 8'hA1;
        #1; chk("pkt_a1_m_tvalid", 32'(p_mv), 0); chk("pkt_a1_fill", 32'(p_fill), 1);
        tick(); p_sd = 8'hA2; p_sl = 1;
        #1; chk("pkt_a2_m_tvalid", 32'(p_mv), 0); chk("pkt_a2_fill", 32'(p_fill), 2);
        tick(); p_sv = 0; p_sl = 0;
        #1; chk("pkt_rd0_m_tvalid", 32'(p_mv), 1); chk("pkt_rd0_data", 32'(p_md), 'hA0);
        chk("pkt_rd0_last", 32'(p_ml), 0); chk("pkt_rd0_pkt", 32'(p_pkt), 1);
        tick();
        #1; chk("pkt_rd1_data", 32'(p_md), 'hA1); chk("pkt_rd1_last", 32'(p_ml), 0);
        tick();
        #1; chk("pkt_rd2_data", 32'(p_md), 'hA2); chk("pkt_rd2_last", 32'(p_ml), 1);
        chk("pkt_rd2_pkt", 32'(p_pkt), 1);
        tick();
        #1; chk("pkt_done_m_tvalid", 32'(p_mv), 0); chk("pkt_done_pkt", 32'(p_pkt), 0);
        chk("pkt_done_fill", 32'(p_fill), 0);

        // Oversize 6-word packet must drain through the full-FIFO escape
        widx = 0; ridx = 0; esc_seen = 0; p_mr = 1;
        for (int c = 0; c < 40 && ridx < 6; c++) begin
            p_sv = (widx < 6); p_sd = 8'(8'hB0 + widx); p_sl = (widx == 5);
            #1;
            if (p_mv && p_fill == 3'd4 && p_pkt == 3'd0) esc_seen = 1;
            if (p_mv) begin
                chk("big_data", 32'(p_md), 32'('hB0 + ridx));
                chk("big_last", 32'(p_ml), 32'(ridx == 5));
                ridx++;
            end
            if (p_sv && p_sr) widx++;
            tick();
        end
        chk("big_words_out", 32'(ridx), 6);
        chk("big_escape_seen", 32'(esc_seen), 1);
        p_sv = 0; p_sl = 0; p_mr = 0;
        #1; chk("big_end_fill", 32'(p_fill), 0); chk("big_end_pkt", 32'(p_pkt), 0);

        // Read of a tlast word concurrent with write of a tlast word
        p_sv = 1; p_sd = 8'hC0; p_sl = 1; p_mr = 0;
        tick();
        p_sd = 8'hC1; p_mr = 1;
        #1; chk("both_m_tvalid", 32'(p_mv), 1); chk("both_data", 32'(p_md), 'hC0);
        chk("both_last", 32'(p_ml), 1);
        tick(); p_sv = 0; p_sl = 0; p_mr = 0;
        #1; chk("both_fill", 32'(p_fill), 1); chk("both_pkt", 32'(p_pkt), 1);
        chk("both_next_data", 32'(p_md), 'hC1);
        p_mr = 1; tick(); p_mr = 0;
        #1; chk("both_drain_fill", 32'(p_fill), 0); chk("both_drain_pkt", 32'(p_pkt), 0);

        // Reset pulse discards stored words and counts
        p_sv = 1; p_sd = 8'hD0; p_sl = 0; tick();
        p_sd = 8'hD1; p_sl = 1; tick();
        p_sd = 8'hD2; p_sl = 0; tick();
        p_sv = 0;
        #1; chk("pre_rst_fill", 32'(p_fill), 3); chk("pre_rst_pkt", 32'(p_pkt), 1);
        chk("pre_rst_m_tvalid", 32'(p_mv), 1);
        resetn = 0; p_mr = 1;
        tick();
        chk("mid_rst_fill", 32'(p_fill), 0); chk("mid_rst_pkt", 32'(p_pkt), 0);
        chk("mid_rst_m_tvalid", 32'(p_mv), 0); chk("mid_rst_aempty", 32'(p_ae), 1);
        chk("mid_rst_s_tready", 32'(p_sr), 0);
        resetn = 1; p_mr = 0;
        tick();
        chk("after_rst_s_tready", 32'(p_sr), 1);
        chk("after_rst_fill", 32'(p_fill), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/crossbar_fifo_pkt.md
CROSSBAR_FIFO_PKT -- requirements
Module: crossbar_fifo_pkt

Interface
REQ-001 Parameter FIFO_DEPTH, default 16: number of entries; SHALL be a power of two, at least 2; all entries usable.
REQ-002 Parameter FIFO_WIDTH, default 32: data width in bits.
REQ-003 Parameter PACKET_MODE, default 0: 0 = word (cut-through) mode, 1 = store-and-forward packet mode.
REQ-004 Parameter AFULL_THRESH, default FIFO_DEPTH-2: almost-full level, range 1..FIFO_DEPTH.
REQ-005 Parameter AEMPTY_THRESH, default 2: almost-empty level, range 0..FIFO_DEPTH-1.
REQ-006 clk  input  1  single clock; all logic on its rising edge.
REQ-007 resetn  input  1  reset; synchronous, active-low.
REQ-008 s_axis_data_tvalid / s_axis_data_tready / s_axis_data_tdata / s_axis_data_tlast  in/out/in/in  1/1/FIFO_WIDTH/1  write stream; tlast marks end of packet, ignored in word mode except as stored sideband.
REQ-009 m_axis_data_tvalid / m_axis_data_tready / m_axis_data_tdata / m_axis_data_tlast  out/in/out/out  1/1/FIFO_WIDTH/1  read stream.
REQ-010 fill_level  output  $clog2(FIFO_DEPTH)+1  number of stored words.
REQ-011 pkt_count  output  $clog2(FIFO_DEPTH)+1  number of stored words carrying tlast=1.
REQ-012 almost_full / almost_empty  output  1/1  threshold flags.

Function
REQ-013 Write transfer: s_tvalid=1 and s_tready=1 on a rising edge; data and tlast stored at write pointer, pointer increments modulo FIFO_DEPTH.
REQ-014 Read transfer: m_tvalid=1 and m_tready=1; read pointer increments modulo FIFO_DEPTH.
REQ-015 m_tdata/m_tlast SHALL be the entry at the read pointer (asynchronous read); word written in cycle N is readable at the earliest in cycle N+1.
REQ-016 s_tready SHALL be 1 when fill_level < FIFO_DEPTH, derived from registered state only (no combinational path from m_tready).
REQ-017 Word mode: m_tvalid = (fill_level != 0).
REQ-018 Packet mode: m_tvalid = (fill_level != 0) and (pkt_count != 0 or fill_level == FIFO_DEPTH); the full-condition term is the oversize escape preventing deadlock on packets longer than FIFO_DEPTH.
REQ-019 fill_level: +1 on write only, -1 on read only, unchanged on simultaneous write and read.
REQ-020 pkt_count: +1 on write with tlast=1, -1 on read with m_tlast=1, unchanged when both occur in the same cycle; maintained in both modes.
REQ-021 Write when full is impossible (s_tready=0); write when full with simultaneous read is refused, since s_tready is already 0.
REQ-022 Read when empty is impossible; write into empty FIFO raises m_tvalid next cycle (word mode), or next cycle after tlast written (packet mode).
REQ-023 almost_full = (fill_level >= AFULL_THRESH); almost_empty = (fill_level <= AEMPTY_THRESH); both combinational from registered fill_level.
REQ-024 Once asserted, m_tvalid SHALL stay asserted with stable m_tdata/m_tlast until the read transfer completes.
REQ-025 Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally; full/empty are distinguished by fill_level, not pointer equality.
REQ-026 Sustained throughput SHALL be one word per cycle with both sides active and the FIFO neither empty (word mode) nor full.

Reset
REQ-027 While resetn=0 at a clock edge: pointers, fill_level, pkt_count cleared; s_tready=0 during reset, 1 from the first cycle after resetn=1.
REQ-028 After reset: m_tvalid=0, fill_level=0, pkt_count=0, almost_full=0, almost_empty=1; storage contents not reset.
REQ-029 Reset asserted mid-operation SHALL discard all stored words and partial packets; no read transfer completes in the reset cycle.

Verification (FIFO_DEPTH=4, FIFO_WIDTH=8)
REQ-030 Word mode, write 0x11,0x22,0x33,0x44 with m_tready=0 -> s_tready=0 after fourth write, fill_level=4, almost_full=1; then drain -> 0x11..0x44 in order, s_tready=1 after first read.
REQ-031 Word mode, continuous write and read for 20 words starting empty -> one word per cycle after first, fill_level stays 1, order preserved across pointer wrap.
REQ-032 Packet mode, write 0xA0,0xA1 (no tlast) with m_tready=1 -> m_tvalid=0; write 0xA2 tlast=1 -> m_tvalid=1 next cycle, 3 words out, tlast on 0xA2, pkt_count 1->0.
REQ-033 Packet mode, 6-word packet, m_tready=1 -> after 4 words FIFO full, m_tvalid=1 via escape, all 6 words delivered, no deadlock.
REQ-034 Packet mode, simultaneous read of tlast word and write of tlast word -> pkt_count unchanged, fill_level unchanged.
REQ-035 Reset pulse with fill_level=3 and pkt_count=1 -> next cycle fill_level=0, pkt_count=0, m_tvalid=0, almost_empty=1.
